// File: rtl/autenticacao_requisitante.sv
// autenticacao_requisitante
//   Initiator side of the credential-authentication path. A code is shifted in
//   serially (A first, F last) and presented in parallel to the external
//   comparator. After the comparator has settled, its AUT1..AUT3 flags are
//   sampled and a grant or deny pulse is issued. Consecutive failures are
//   counted, and reaching MAX_TRIES starts a timed lockout.
//
//   Optional feature macro: AUT_TIMEOUT_EN
//     When defined, a partial entry that sits idle for TIMEOUT_CYCLES cycles
//     is discarded. When undefined, a partial entry is held indefinitely.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   bit_in     in   1       serial code bit
//   bit_valid  in   1       bit_in valid (COLLECT only)
//   abort      in   1       discard partial entry (COLLECT only)
//   aut_in     in   3       {AUT1,AUT2,AUT3} from comparator
//   code_out   out  CODE_W  parallel code {A..F}
//   code_valid out  1       code_out under evaluation
//   grant      out  1       access granted pulse (HOLD_CYCLES)
//   deny       out  1       access denied pulse (HOLD_CYCLES)
//   user_id    out  2       matched comparator slot while grant is high
//   locked     out  1       lockout active
//   fail_cnt   out  4       consecutive failures
//   bit_cnt    out  3       bits collected in current entry
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_COLLECT | shifting in code bits; abort / idle timeout clear entry
// ST_EVAL    | code frozen, waiting EVAL_WAIT cycles for comparator
// ST_GRANT   | grant pulse, user_id valid
// ST_DENY    | deny pulse; may lead into lockout
// ST_LOCKOUT | all input ignored for LOCK_CYCLES

module autenticacao_requisitante #(
  parameter int CODE_W         = 6,
  parameter int EVAL_WAIT      = 2,
  parameter int HOLD_CYCLES    = 50,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              abort,
  input  logic [2:0]        aut_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic              grant,
  output logic              deny,
  output logic [1:0]        user_id,
  output logic              locked,
  output logic [3:0]        fail_cnt,
  output logic [2:0]        bit_cnt
);

  localparam int MAX_A = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int MAX_B = (MAX_A > EVAL_WAIT) ? MAX_A : EVAL_WAIT;
`ifdef AUT_TIMEOUT_EN
  localparam int TMR_MAX = (MAX_B > TIMEOUT_CYCLES) ? MAX_B : TIMEOUT_CYCLES;
`else
  localparam int TMR_MAX = MAX_B;
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_EVAL,
    ST_GRANT,
    ST_DENY,
    ST_LOCKOUT
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_load;
  logic             tmr_done;
  logic             shift_en;
  logic             last_bit;
  logic             clr_entry;
  logic             clr_code;
  logic             fail_inc;
  logic             fail_clr;
  logic [1:0]       uid_sel;

  assign tmr_done = (tmr_q == '0);
  assign last_bit = (bit_cnt == 3'(CODE_W - 1));

  // AUT1 sits in the MSB and has the highest priority.
  always_comb begin
    uid_sel = 2'd0;
    if (aut_in[2])      uid_sel = 2'd1;
    else if (aut_in[1]) uid_sel = 2'd2;
    else if (aut_in[0]) uid_sel = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  // One down-counter times every state; it is reloaded on each state entry
  // and the state ends when it reaches zero.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    shift_en  = 1'b0;
    clr_entry = 1'b0;
    clr_code  = 1'b0;
    fail_inc  = 1'b0;
    fail_clr  = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (abort) begin
          clr_entry = 1'b1;
        end else if (bit_valid) begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_d  = ST_EVAL;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(EVAL_WAIT - 1);
          end
`ifdef AUT_TIMEOUT_EN
          else begin
            // In COLLECT the timer doubles as the inter-bit idle counter.
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TIMEOUT_CYCLES - 1);
          end
        end else if (bit_cnt != '0 && tmr_done) begin
          clr_entry = 1'b1;
`endif
        end
      end
      ST_EVAL: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(HOLD_CYCLES - 1);
          if (aut_in != 3'b000) begin
            state_d  = ST_GRANT;
            fail_clr = 1'b1;
          end else begin
            state_d  = ST_DENY;
            fail_inc = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (tmr_done) begin
          state_d  = ST_COLLECT;
          clr_code = 1'b1;
        end
      end
      ST_DENY: begin
        if (tmr_done) begin
          clr_code = 1'b1;
          if (fail_cnt == 4'(MAX_TRIES)) begin
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCK_CYCLES - 1);
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d  = ST_COLLECT;
          fail_clr = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q      <= '0;
      code_out   <= '0;
      bit_cnt    <= '0;
      fail_cnt   <= '0;
      code_valid <= 1'b0;
      grant      <= 1'b0;
      deny       <= 1'b0;
      locked     <= 1'b0;
      user_id    <= 2'd0;
    end else begin
      if (tmr_load)      tmr_q <= tmr_val;
      else if (!tmr_done) tmr_q <= tmr_q - TMR_W'(1);

      if (clr_entry || clr_code) code_out <= '0;
      else if (shift_en)         code_out <= {code_out[CODE_W-2:0], bit_in};

      if (clr_entry || (shift_en && last_bit)) bit_cnt <= '0;
      else if (shift_en)                       bit_cnt <= bit_cnt + 3'd1;

      if (fail_clr)                                      fail_cnt <= '0;
      else if (fail_inc && fail_cnt != 4'(MAX_TRIES))    fail_cnt <= fail_cnt + 4'd1;

      code_valid <= (state_d == ST_EVAL);
      grant      <= (state_d == ST_GRANT);
      deny       <= (state_d == ST_DENY);
      locked     <= (state_d == ST_LOCKOUT);

      // user_id is captured on the EVAL->GRANT edge and held for the pulse.
      if (state_d != ST_GRANT)   user_id <= 2'd0;
      else if (state_q == ST_EVAL) user_id <= uid_sel;
    end
  end

endmodule

// File: tb/tb_autenticacao_requisitante.sv
module tb_autenticacao_requisitante;

  localparam int EW   = 2;
  localparam int HOLD = 50;
  localparam int MAXT = 3;
  localparam int LOCK = 1000;
  localparam int TOUT = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] aut_in = 3'b000;
  logic [5:0] code_out;
  logic       code_valid, grant, deny, locked;
  logic [1:0] user_id;
  logic [3:0] fail_cnt;
  logic [2:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  int m_fail = 0;   // model: consecutive failures

  always #5 clk = ~clk;

  autenticacao_requisitante dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .abort(abort), .aut_in(aut_in), .code_out(code_out),
    .code_valid(code_valid), .grant(grant), .deny(deny), .user_id(user_id),
    .locked(locked), .fail_cnt(fail_cnt), .bit_cnt(bit_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [5:0] code, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bit_in    = code[5-i];
      bit_valid = 1'b1;
      tick();
      if (i < 5) chk("bit_cnt_shift", bit_cnt, i + 1);
    end
    bit_valid = 1'b0;
  endtask

  task automatic noise(input bit en);
    if (en) begin
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      abort     = 1'($urandom);
    end
  endtask

  // Full entry with outcome prediction from the decision rules.
  task automatic run_entry(input logic [5:0] code, input logic [2:0] aut, input bit nz);
    int   n;
    bit   exp_g;
    int   exp_u;
    exp_u = 0;
    for (int i = 0; i < 3; i++)
      if (exp_u == 0 && aut[2-i]) exp_u = i + 1;
    exp_g  = (aut != 3'b000);
    aut_in = aut;
    shift_bits(code, 6);
    chk("code_out", code_out, code);
    chk("code_valid", code_valid, 1);
    chk("bit_cnt_clr", bit_cnt, 0);
    n = 1;
    while (code_valid === 1'b1 && n < 20) begin
      noise(nz);
      tick();
      if (code_valid === 1'b1) n++;
    end
    chk("eval_len", n, EW);
    chk("grant", grant, exp_g);
    chk("deny", deny, !exp_g);
    chk("user_id", user_id, exp_g ? exp_u : 0);
    if (exp_g) m_fail = 0;
    else       m_fail = m_fail + 1;
    chk("fail_cnt", fail_cnt, m_fail);
    n = 1;
    while ((grant === 1'b1 || deny === 1'b1) && n < HOLD + 10) begin
      noise(nz);
      tick();
      if (grant === 1'b1 || deny === 1'b1) n++;
    end
    bit_valid = 1'b0;
    abort     = 1'b0;
    chk("hold_len", n, HOLD);
    if (!exp_g && m_fail == MAXT) begin
      chk("locked_on", locked, 1);
      n = 1;
      while (locked === 1'b1 && n < LOCK + 10) begin
        noise(nz);
        tick();
        if (locked === 1'b1) n++;
      end
      bit_valid = 1'b0;
      abort     = 1'b0;
      chk("lock_len", n, LOCK);
      m_fail = 0;
    end
    chk("idle_flags", {grant, deny, locked, code_valid}, 0);
    chk("fail_after", fail_cnt, m_fail);
    chk("bit_cnt_after", bit_cnt, 0);
    chk("code_after", code_out, 0);
  endtask

  initial begin
    logic [5:0] rc;
    logic [2:0] ra;
    // reset state
    #2;
    chk("rst_all", {code_out, code_valid, grant, deny, user_id, locked, fail_cnt, bit_cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst", {code_out, code_valid, grant, deny, user_id, locked, fail_cnt, bit_cnt}, 0);

    // directed: grant via AUT1, priority AUT2 over AUT3
    run_entry(6'b101100, 3'b100, 1'b0);
    run_entry(6'b010011, 3'b011, 1'b1);
    // first deny, then abort must not touch fail_cnt
    run_entry(6'b111000, 3'b000, 1'b0);
    shift_bits(6'b110100, 4);
    chk("bit_cnt_4", bit_cnt, 4);
    chk("code_4", code_out, 6'b001101);
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0;
    chk("abort_cnt", bit_cnt, 0);
    chk("abort_code", code_out, 0);
    chk("abort_fail", fail_cnt, m_fail);
    // two more denies -> lockout with noise driven throughout
    run_entry(6'b000111, 3'b000, 1'b1);
    run_entry(6'b011110, 3'b000, 1'b1);

    // randomized entries against the model
    for (int k = 0; k < 14; k++) begin
      rc = 6'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run_entry(rc, ra, 1'($urandom));
    end

    // idle behaviour of a partial entry
    shift_bits(6'b101000, 3);
    for (int i = 0; i < TOUT - 1; i++) tick();
    chk("idle_199", bit_cnt, 3);
    tick();
`ifdef AUT_TIMEOUT_EN
    chk("idle_200", bit_cnt, 0);
`else
    chk("idle_200", bit_cnt, 3);
`endif
    chk("idle_fail", fail_cnt, m_fail);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort", bit_cnt, 0);

    // asynchronous reset during EVAL
    aut_in = 3'b100;
    shift_bits(6'b100001, 6);
    chk("pre_rst_eval", code_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_eval", {code_out, code_valid, grant, deny, user_id, locked, fail_cnt, bit_cnt}, 0);
    tick();
    rst_n = 1'b1;
    m_fail = 0;
    tick();
    chk("rst_eval_st", {code_valid, grant, deny, locked}, 0);

    // asynchronous reset during GRANT
    aut_in = 3'b001;
    shift_bits(6'b011011, 6);
    for (int i = 0; i < EW; i++) tick();
    chk("pre_rst_grant", {grant, user_id}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", {code_out, code_valid, grant, deny, user_id, locked, fail_cnt, bit_cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_entry(6'b110011, 3'b010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
